mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single 16x8 main memory between the CPU's fetch/execute datapath and a host loader/debug port. Each cycle it grants at most one requester, drives the memory's single synchronous port, and routes read data back with a one-cycle valid. A lock holds ownership across back-to-back accesses so CPU read-modify-write instructions (double, complement) are atomic against host traffic.

## Interface
Parameters:
- ADDR_W, 4, memory address width (depth = 2**ADDR_W)
- DATA_W, 8, memory word width
- LOCK_MAX, 4, maximum consecutive cycles a lock may be held, range 1..15

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req / host_req  in  1  access request, held until granted
- cpu_we / host_we  in  1  1 = write, 0 = read
- cpu_lock / host_lock  in  1  keep ownership after this access
- cpu_addr / host_addr  in  ADDR_W  word address
- cpu_wdata / host_wdata  in  DATA_W  write data
- cpu_gnt / host_gnt  out  1  combinational; access accepted this cycle
- cpu_rvalid / host_rvalid  out  1  registered; read data valid this cycle
- cpu_rdata / host_rdata  out  DATA_W  mem_rdata passed through to both
- mem_en  out  1  memory access this cycle (= cpu_gnt | host_gnt)
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  muxed from the winner
- mem_rdata  in  DATA_W  synchronous read data, valid 1 cycle after mem_en & !mem_we

## Operation
- States: UNLOCKED, LOCK_CPU, LOCK_HOST.
- UNLOCKED, one requester active: that requester is granted.
- UNLOCKED, both active: round-robin. The side that is not `last_win` is granted. `last_win` is updated on every grant and resets to HOST, so the CPU wins the first conflict.
- Granted access with its lock = 1: go to LOCK_<side> and load the lock counter with 1.
- LOCK_x: only x can be granted, and the other side's req is ignored. Idle cycles still count toward the lock.
- LOCK_x exits to UNLOCKED in either of these cases:
  - x is granted with lock = 0.
  - The counter reaches LOCK_MAX. The forced release takes effect after that cycle's access completes.
- LOCK_x, grant with lock = 1 and counter < LOCK_MAX: stay in LOCK_x and increment the counter.
- Non-granted side's gnt = 0. Its request stays pending; there is no queueing inside the block.
- Write: mem_we = 1 with data in the grant cycle. No rvalid is produced.
- Read: the rvalid of the granted side is asserted in the following cycle. The rdata outputs are always mem_rdata; consumers qualify with rvalid.
- Back-to-back reads from different sides each produce rvalid to the correct side. The in-flight owner is tracked in a 1-entry register.
- gnt, mem_en and mem_we are forced to 0 while rst_n is low.

## Timing
- Reset values:
  - cpu_rvalid = host_rvalid = 0.
  - State = UNLOCKED, lock counter = 0, last_win = HOST, in-flight owner = none.
- Grant latency is 0 cycles (same cycle as req when eligible).
- Read data latency is 1 cycle after grant.
- One access per cycle maximum, giving full throughput for a single requester.
- Reset asserted mid-read: the pending rvalid is dropped and never appears after reset release.
- Reset asserted mid-lock: the lock is released.
- A request with lock = 1 from the non-owner during LOCK_x has no effect until it is granted.

## Configuration
- MEM_ARB_FIXED_PRI_EN defined: fixed priority replaces round-robin. The host always wins UNLOCKED conflicts, and last_win is unused.
- MEM_ARB_FIXED_PRI_EN undefined: round-robin as above.
- Lock behaviour is identical in both builds.

## Structure
- Package mem_arb_pkg holds:
  - state enum {ST_UNLOCKED, ST_LOCK_CPU, ST_LOCK_HOST}.
  - owner enum {OWN_NONE, OWN_CPU, OWN_HOST}.
  - LOCK_CNT_W = 4.
- Sub-module mem_arb_lock_timer: lock counter with load, increment and expire outputs.
- Grant logic, muxing and rvalid tracking stay in the top module.

## Test plan
- Reset release, cpu_req read addr 3 alone -> cpu_gnt=1 same cycle, mem_addr=3; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata.
- Both req continuously (round-robin build) -> grants alternate CPU, HOST, CPU, HOST starting with CPU.
- CPU read addr 5 with lock=1, then write addr 5 with lock=0, host_req held throughout -> host_gnt=0 for both CPU cycles, host granted on the third cycle.
- CPU holds lock=1 for 6 cycles, LOCK_MAX=4, host_req held -> forced release after the 4th CPU cycle; host granted on the 5th.
- Host read addr 2 then CPU read addr 7 on consecutive cycles -> host_rvalid on cycle+1, cpu_rvalid on cycle+2, never both in one cycle.
- rst_n pulled low the cycle after a granted read -> no rvalid after release, state UNLOCKED, first conflict won by CPU (or by host with MEM_ARB_FIXED_PRI_EN).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: arbiter states, read-data owner tags
// and the lock counter width.
package mem_arb_pkg;

  localparam int LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LOCK_CPU,
    ST_LOCK_HOST
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } owner_e;

endpackage

// File: rtl/mem_arb_lock_timer.sv
// Lock hold counter: counts cycles a side has held the memory lock.
// expire flags that the cycle being counted now is the last allowed one.
module mem_arb_lock_timer
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic                  clr,
  output logic [LOCK_CNT_W-1:0] cnt,
  output logic                  expire
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOCK_CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (int'(cnt) + 1) >= LOCK_MAX;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/host arbiter for the shared single-port memory, with atomic lock.
// MEM_ARB_FIXED_PRI_EN: host always wins unlocked conflicts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A one-cycle cap means the granting cycle already uses up the lock.
  localparam bit CAN_LOCK = LOCK_MAX > 1;

  state_e state_q, state_d;
  owner_e infl_q;

  logic cpu_win, host_win;
  logic cpu_pri;
  logic t_load, t_inc, t_clr, t_expire;
  logic [LOCK_CNT_W-1:0] t_cnt;

`ifdef MEM_ARB_FIXED_PRI_EN
  assign cpu_pri = 1'b0;
`else
  logic last_cpu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cpu_q <= 1'b0;
    end else if (cpu_gnt) begin
      last_cpu_q <= 1'b1;
    end else if (host_gnt) begin
      last_cpu_q <= 1'b0;
    end
  end

  assign cpu_pri = ~last_cpu_q;
`endif

  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    unique case (state_q)
      ST_UNLOCKED: begin
        cpu_win  = cpu_req & (~host_req | cpu_pri);
        host_win = host_req & ~cpu_win;
      end
      ST_LOCK_CPU:  cpu_win  = cpu_req;
      ST_LOCK_HOST: host_win = host_req;
      default: ;
    endcase
  end

  assign cpu_gnt  = cpu_win & rst_n;
  assign host_gnt = host_win & rst_n;

  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_inc   = 1'b0;
    t_clr   = 1'b0;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (CAN_LOCK && cpu_win && cpu_lock) begin
          state_d = ST_LOCK_CPU;
          t_load  = 1'b1;
        end else if (CAN_LOCK && host_win && host_lock) begin
          state_d = ST_LOCK_HOST;
          t_load  = 1'b1;
        end
      end
      ST_LOCK_CPU: begin
        if ((cpu_win && !cpu_lock) || t_expire) begin
          state_d = ST_UNLOCKED;
          t_clr   = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_LOCK_HOST: begin
        if ((host_win && !host_lock) || t_expire) begin
          state_d = ST_UNLOCKED;
          t_clr   = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        t_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  mem_arb_lock_timer #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (t_load),
    .inc    (t_inc),
    .clr    (t_clr),
    .cnt    (t_cnt),
    .expire (t_expire)
  );

  assign mem_en    = cpu_gnt | host_gnt;
  assign mem_we    = host_gnt ? host_we : (cpu_gnt & cpu_we);
  assign mem_addr  = host_gnt ? host_addr : cpu_addr;
  assign mem_wdata = host_gnt ? host_wdata : cpu_wdata;

  // Single in-flight read: the memory returns data exactly one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= OWN_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      infl_q <= OWN_CPU;
    end else if (host_gnt && !host_we) begin
      infl_q <= OWN_HOST;
    end else begin
      infl_q <= OWN_NONE;
    end
  end

  assign cpu_rvalid  = (infl_q == OWN_CPU);
  assign host_rvalid = (infl_q == OWN_HOST);
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LOCK_MAX (LM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_lock    (cpu_lock),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  typedef struct packed {
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rq_t;

  typedef struct {
    bit            cg;
    bit            hg;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gexp_t;

  typedef struct {
    int            side;
    logic [DW-1:0] data;
    int            due;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: who owns the lock (0 none, 1 cpu, 2 host), cycles held,
  // and the last winner for round-robin fairness.
  int lk_side = 0;
  int held    = 0;
  int last    = 2;

  task automatic model(input rq_t c, input rq_t h, output int w);
    logic lk;
    w = 0;
    if (lk_side == 0) begin
      if (c.req && h.req) begin
`ifdef MEM_ARB_FIXED_PRI_EN
        w = 2;
`else
        w = (last == 1) ? 2 : 1;
`endif
      end else if (c.req) w = 1;
      else if (h.req) w = 2;
    end else if (lk_side == 1) begin
      if (c.req) w = 1;
    end else begin
      if (h.req) w = 2;
    end
    if (w != 0) last = w;
    lk = (w == 1) ? c.lock : (w == 2) ? h.lock : 1'b0;
    if (lk_side == 0) begin
      if (w != 0 && lk && LM > 1) begin
        lk_side = w;
        held    = 1;
      end
    end else begin
      held++;
      if ((w != 0 && !lk) || held >= LM) begin
        lk_side = 0;
        held    = 0;
      end
    end
  endtask

  function automatic rq_t mk(input logic req, input logic we,
                             input logic lock, input int a, input int d);
    rq_t r;
    r.req   = req;
    r.we    = we;
    r.lock  = lock;
    r.addr  = a[AW-1:0];
    r.wdata = d[DW-1:0];
    return r;
  endfunction

  task automatic drive(input rq_t c, input rq_t h);
    cpu_req    = c.req;
    cpu_we     = c.we;
    cpu_lock   = c.lock;
    cpu_addr   = c.addr;
    cpu_wdata  = c.wdata;
    host_req   = h.req;
    host_we    = h.we;
    host_lock  = h.lock;
    host_addr  = h.addr;
    host_wdata = h.wdata;
  endtask

  // One cycle: drive, predict, queue expectations; aw is the DUT's winner.
  task automatic step(input rq_t c, input rq_t h, output int w,
                      output int aw);
    gexp_t g;
    rexp_t r;
    rq_t   x;
    @(posedge clk);
    #1;
    drive(c, h);
    model(c, h, w);
    g.cg    = (w == 1);
    g.hg    = (w == 2);
    x       = (w == 2) ? h : c;
    g.we    = (w != 0) && x.we;
    g.addr  = x.addr;
    g.wdata = x.wdata;
    gq.push_back(g);
    if (w != 0) begin
      if (x.we) begin
        ref_mem[x.addr] = x.wdata;
      end else begin
        r.side = w;
        r.data = ref_mem[x.addr];
        r.due  = cyc + 1;
        rq.push_back(r);
      end
    end
    #1;
    aw = cpu_gnt ? 1 : host_gnt ? 2 : 0;
  endtask

  task automatic do_reset(input int n);
    gexp_t g;
    g = '{0, 0, 0, '0, '0};
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(mk(1, 0, 1, 1, 0), mk(1, 0, 1, 2, 0));
      rq.delete();
      lk_side = 0;
      held    = 0;
      last    = 2;
      gq.push_back(g);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive('0, '0);
    gq.push_back(g);
  endtask

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (gq.size() > 0) begin
      g = gq.pop_front();
      chk("cpu_gnt", cpu_gnt, g.cg);
      chk("host_gnt", host_gnt, g.hg);
      chk("mem_en", mem_en, g.cg | g.hg);
      if (g.cg || g.hg) begin
        chk("mem_we", mem_we, g.we);
        chk("mem_addr", mem_addr, g.addr);
        if (g.we) chk("mem_wdata", mem_wdata, g.wdata);
      end else begin
        chk("mem_we_idle", mem_we, 0);
      end
    end
    if (cpu_rvalid || host_rvalid) begin
      chk("rvalid_both", cpu_rvalid & host_rvalid, 0);
      if (rq.size() == 0) begin
        chk("spurious_rvalid", 1, 0);
      end else begin
        r = rq.pop_front();
        chk("rvalid_side", cpu_rvalid ? 1 : 2, r.side);
        chk("rvalid_cycle", cyc, r.due);
        chk("rdata", cpu_rvalid ? cpu_rdata : host_rdata, r.data);
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      chk("missing_rvalid", 0, 1);
      void'(rq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rq_t c, h;
    int  w, aw;
    int  exp2 [4];
    int  exp4 [6];

    for (int i = 0; i < 16; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    drive(mk(1, 0, 1, 1, 0), mk(1, 0, 1, 2, 0));
    #3;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    do_reset(1);

    // Lone CPU read of address 3.
    step(mk(1, 0, 0, 3, 0), '0, w, aw);
    chk("t1_gnt", aw, 1);
    chk("t1_addr", mem_addr, 3);
    step('0, '0, w, aw);

    // Continuous conflict.
`ifdef MEM_ARB_FIXED_PRI_EN
    exp2 = '{2, 2, 2, 2};
`else
    exp2 = '{1, 2, 1, 2};
`endif
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 0, 0, i, 0), mk(1, 0, 0, i + 8, 0), w, aw);
      chk("t2_alternate", aw, exp2[i]);
    end

    // Atomic read-modify-write against a waiting host.
    do_reset(1);
    step(mk(1, 0, 1, 5, 0), '0, w, aw);
    chk("t3_rd", aw, 1);
    step(mk(1, 1, 0, 5, 8'ha5), mk(1, 0, 0, 9, 0), w, aw);
    chk("t3_wr", aw, 1);
    step('0, mk(1, 0, 0, 9, 0), w, aw);
    chk("t3_host", aw, 2);

    // Lock held past LOCK_MAX is forcibly released.
    exp4 = '{1, 1, 1, 1, 2, 1};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(mk(1, i[0], 1, i, i * 3),
           (i >= 1 && i <= 4) ? mk(1, 0, 0, 12, 0) : '0, w, aw);
      chk("t4_lockmax", aw, exp4[i]);
    end

    // Back-to-back reads from different sides.
    do_reset(1);
    step('0, mk(1, 0, 0, 2, 0), w, aw);
    chk("t5_host", aw, 2);
    step(mk(1, 0, 0, 7, 0), '0, w, aw);
    chk("t5_cpu", aw, 1);
    step('0, '0, w, aw);
    step('0, '0, w, aw);

    // Reset right after a granted locked read.
    step(mk(1, 0, 1, 4, 0), '0, w, aw);
    chk("t6_rd", aw, 1);
    do_reset(1);
    step(mk(1, 0, 0, 6, 0), mk(1, 0, 0, 11, 0), w, aw);
`ifdef MEM_ARB_FIXED_PRI_EN
    chk("t6_first", aw, 2);
`else
    chk("t6_first", aw, 1);
`endif
    step(mk(1, 0, 0, 6, 0), mk(1, 0, 0, 11, 0), w, aw);
    chk("t6_second", aw, 2);
    step('0, '0, w, aw);

    // Random traffic: requests held until granted.
    c = '0;
    h = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!c.req && $urandom_range(2) != 0)
        c = mk(1, 1'($urandom_range(1)), $urandom_range(3) == 0,
               $urandom_range(15), $urandom_range(255));
      if (!h.req && $urandom_range(2) != 0)
        h = mk(1, 1'($urandom_range(1)), $urandom_range(3) == 0,
               $urandom_range(15), $urandom_range(255));
      step(c, h, w, aw);
      if (w == 1) c.req = 1'b0;
      if (w == 2) h.req = 1'b0;
    end

    step('0, '0, w, aw);
    step('0, '0, w, aw);
    @(posedge clk);
    #1;
    chk("rq_drained", rq.size(), 0);
    chk("gq_drained", gq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
